mem_access: RTL and testbench

Memory-access (MEM) stage of the five-stage MIPS pipeline, between the `ex_mem` pipeline register and `mem_wb`. It runs loads and stores against the data bus with a req/ack handshake and builds byte selects and load sign/zero extension. It drives the `mem_*` signals registered by `mem_wb`, and raises `stallreq` while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_access.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MIPS MEM stage. Issues loads and stores on a req/ack data bus, builds byte lanes and
// load extension, and requests a pipeline stall while a bus transaction is outstanding.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [31:0]       ex_pc,
    input  logic [7:0]        ex_aluop,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_reg2,
    input  logic              hold,
    input  logic              flush,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       mem_pc,
    output logic [7:0]        mem_aluop,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic [DATA_W-1:0] dbus_rdata,
    input  logic              dbus_ack,
    output logic              stallreq,
    output logic              excp_adel,
    output logic              excp_ades,
    output logic [1:0]        dbg_state
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_signed;
    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic              w_misalign;
    logic              w_issue;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_store_data;
    logic [ADDR_W-1:0] w_aligned_addr;
    logic              w_req;
    logic              w_we;
    logic              w_stall;
    logic              w_nop;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_bsel;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_src;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_val;

    // w_size: 0 = byte, 1 = halfword, 2 = word
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = 2'd0;
        case (ex_aluop)
            EXE_LB_OP:  begin w_is_load = 1'b1; w_signed = 1'b1; end
            EXE_LBU_OP: begin w_is_load = 1'b1; end
            EXE_LH_OP:  begin w_is_load = 1'b1; w_signed = 1'b1; w_size = 2'd1; end
            EXE_LHU_OP: begin w_is_load = 1'b1; w_size = 2'd1; end
            EXE_LW_OP:  begin w_is_load = 1'b1; w_size = 2'd2; end
            EXE_SB_OP:  begin w_is_store = 1'b1; end
            EXE_SH_OP:  begin w_is_store = 1'b1; w_size = 2'd1; end
            EXE_SW_OP:  begin w_is_store = 1'b1; w_size = 2'd2; end
            default:    ;
        endcase
    end

    assign w_off          = ex_mem_addr[1:0];
    assign w_aligned_addr = {ex_mem_addr[ADDR_W-1:2], 2'b00};
    assign w_misalign     = (w_is_load | w_is_store) &
                            (((w_size == 2'd1) & w_off[0]) | ((w_size == 2'd2) & (w_off != 2'd0)));
    assign w_issue        = (w_is_load | w_is_store) & !w_misalign & !flush;

    // Big-endian lanes: byte offset 0 is the most significant lane.
    always_comb begin
        case (w_size)
            2'd0: begin
                w_sel        = 4'b1000 >> w_off;
                w_store_data = {(DATA_W/8){ex_reg2[7:0]}};
            end
            2'd1: begin
                w_sel        = w_off[1] ? 4'b0011 : 4'b1100;
                w_store_data = {(DATA_W/16){ex_reg2[15:0]}};
            end
            default: begin
                w_sel        = 4'b1111;
                w_store_data = ex_reg2;
            end
        endcase
    end

    // Handshake: dbus_req rises with one access's fields and holds them unchanged until the
    // cycle with dbus_ack=1; that cycle completes the access. dbus_ack with dbus_req=0 is ignored.
    always_comb begin
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_bsel   = '0;
        w_wdata  = '0;
        w_stall  = 1'b0;
        w_nop    = flush;
        w_rd_src = dbus_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_req   = 1'b1;
                    w_we    = w_is_store;
                    w_addr  = w_aligned_addr;
                    w_bsel  = w_sel;
                    w_wdata = w_store_data;
                    w_stall = !dbus_ack;
                end
            end
            S_WAIT: begin
                w_req   = 1'b1;
                w_we    = r_we;
                w_addr  = r_addr;
                w_bsel  = r_sel;
                w_wdata = r_wdata;
                w_stall = !dbus_ack;
            end
            S_DONE: begin
                w_rd_src = r_rdata;
            end
            S_DRAIN: begin
                w_req   = 1'b1;
                w_we    = r_we;
                w_addr  = r_addr;
                w_bsel  = r_sel;
                w_wdata = r_wdata;
                w_stall = 1'b1;
                w_nop   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_shifted = w_rd_src << {w_off, 3'b000};
        case (w_size)
            2'd0:    w_load_val = {{(DATA_W-8){w_signed & w_shifted[DATA_W-1]}}, w_shifted[DATA_W-1 -: 8]};
            2'd1:    w_load_val = {{(DATA_W-16){w_signed & w_shifted[DATA_W-1]}}, w_shifted[DATA_W-1 -: 16]};
            default: w_load_val = w_rd_src;
        endcase
    end

    always_comb begin
        mem_wd     = '0;
        mem_wreg   = 1'b0;
        mem_wdata  = '0;
        mem_pc     = '0;
        mem_aluop  = '0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_sel   = '0;
        dbus_wdata = '0;
        stallreq   = 1'b0;
        excp_adel  = 1'b0;
        excp_ades  = 1'b0;
        if (!rst) begin
            mem_pc     = ex_pc;
            mem_aluop  = ex_aluop;
            dbus_req   = w_req;
            dbus_we    = w_we;
            dbus_addr  = w_addr;
            dbus_sel   = w_bsel;
            dbus_wdata = w_wdata;
            stallreq   = w_stall;
            if (!w_nop) begin
                mem_wd    = ex_wd;
                mem_wreg  = ex_wreg & !w_is_store & !w_misalign;
                mem_wdata = w_is_load ? (w_misalign ? '0 : w_load_val) : ex_wdata;
                excp_adel = w_is_load & w_misalign;
                excp_ades = w_is_store & w_misalign;
            end
        end
    end

    // Request fields are latched on entry to WAIT so a flush cannot disturb them in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        if (dbus_ack) begin
                            if (hold) begin
                                r_rdata <= dbus_rdata;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_addr  <= w_aligned_addr;
                            r_sel   <= w_sel;
                            r_we    <= w_is_store;
                            r_wdata <= w_store_data;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dbus_ack) begin
                        if (hold && !flush) begin
                            r_rdata <= dbus_rdata;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush || !hold) r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (dbus_ack) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = r_state;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed MEM-stage scenarios plus random aligned accesses, with
// expected write-back data queued at drive time and checked when each access completes.
module tb_mem_access;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_pc;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic        hold;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [7:0]  mem_aluop;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        stallreq;
    logic        excp_adel;
    logic        excp_ades;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_pc(ex_pc),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hold(hold), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_aluop(mem_aluop),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .stallreq(stallreq), .excp_adel(excp_adel), .excp_ades(excp_ades),
        .dbg_state(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                case (addr[1:0])
                    2'd0:    return 4'b1000;
                    2'd1:    return 4'b0100;
                    2'd2:    return 4'b0010;
                    default: return 4'b0001;
                endcase
            end
            OP_LH, OP_LHU, OP_SH: return addr[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] rt);
        case (op)
            OP_SB:   return {4{rt[7:0]}};
            OP_SH:   return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] model_result(input logic [7:0] op, input logic [31:0] addr,
                                                 input logic [31:0] rd, input logic [31:0] pass);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr[1:0])
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = addr[1] ? rd[15:0] : rd[31:16];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            OP_LW:   return rd;
            default: return pass;
        endcase
    endfunction

    task automatic drive_nop();
        ex_aluop    = 8'h00;
        ex_mem_addr = 32'h0;
        ex_reg2     = 32'h0;
        ex_wdata    = 32'h0;
        ex_wd       = 5'd0;
        ex_wreg     = 1'b0;
        dbus_ack    = 1'b0;
        hold        = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access has completed.
    task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                              input logic [31:0] rdata, input int waits, input int hold_cyc);
        logic [31:0] pass_val;
        logic [31:0] pc;
        logic [31:0] exp_v;
        logic        is_store;
        int          stalls;
        int          reqs;
        pass_val    = {addr[15:0], rt[15:0]} ^ 32'h00A5_5A00;
        pc          = 32'h0040_0000 + addr;
        is_store    = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        ex_aluop    = op;
        ex_mem_addr = addr;
        ex_reg2     = rt;
        ex_wdata    = pass_val;
        ex_wd       = 5'd9;
        ex_wreg     = 1'b1;
        ex_pc       = pc;
        flush       = 1'b0;
        hold        = 1'b0;
        exp_q.push_back(model_result(op, addr, rdata, pass_val));
        stalls = 0;
        reqs   = 0;
        for (int c = 0; c < waits; c++) begin
            dbus_ack   = 1'b0;
            dbus_rdata = $urandom;
            @(negedge clk);
            if (stallreq) stalls++;
            check_eq("wait_req", {31'h0, dbus_req}, 32'h1);
            check_eq("wait_sel", {28'h0, dbus_sel}, {28'h0, model_sel(op, addr)});
            check_eq("wait_addr", dbus_addr, {addr[31:2], 2'b00});
            next_cycle();
        end
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
        hold       = (hold_cyc > 0);
        @(negedge clk);
        if (stallreq) stalls++;
        if (dbus_req) reqs++;
        check_eq("ack_sel", {28'h0, dbus_sel}, {28'h0, model_sel(op, addr)});
        check_eq("ack_addr", dbus_addr, {addr[31:2], 2'b00});
        check_eq("ack_we", {31'h0, dbus_we}, {31'h0, is_store});
        if (is_store) check_eq("ack_wdata", dbus_wdata, model_store(op, rt));
        check_eq("stall_cycles", stalls, waits);
        for (int c = 1; c <= hold_cyc; c++) begin
            next_cycle();
            dbus_ack   = 1'b1;
            dbus_rdata = $urandom;
            hold       = (c < hold_cyc);
            @(negedge clk);
            if (dbus_req) reqs++;
            check_eq("done_stall", {31'h0, stallreq}, 32'h0);
            check_eq("done_state", {30'h0, dbg_state}, {30'h0, ST_DONE});
            if (c < hold_cyc) check_eq("done_data", mem_wdata, exp_q[0]);
        end
        exp_v = exp_q.pop_front();
        check_eq("mem_wdata", mem_wdata, exp_v);
        check_eq("mem_wreg", {31'h0, mem_wreg}, {31'h0, !is_store});
        check_eq("mem_pc", mem_pc, pc);
        check_eq("req_count", reqs, 1);
        next_cycle();
        drive_nop();
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] addr;
        rst        = 1'b1;
        ex_pc      = 32'h0;
        dbus_rdata = 32'h8011_2233;
        drive_nop();
        ex_aluop    = OP_LB;
        ex_mem_addr = 32'h104;
        ex_wreg     = 1'b1;
        dbus_ack    = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_req", {31'h0, dbus_req}, 32'h0);
        check_eq("rst_stall", {31'h0, stallreq}, 32'h0);
        check_eq("rst_wreg", {31'h0, mem_wreg}, 32'h0);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_excp", {30'h0, excp_adel, excp_ades}, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive_nop();
        next_cycle();

        // LB sign-extended, zero wait
        run_access(OP_LB, 32'h104, 32'h0, 32'h8011_2233, 0, 0);
        // LHU with three wait states
        run_access(OP_LHU, 32'h102, 32'h0, 32'h1234_ABCD, 3, 0);
        // SB lane replication
        run_access(OP_SB, 32'h203, 32'h0000_00EE, 32'h0, 0, 0);
        // LW acked under two cycles of hold
        run_access(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 2);
        run_access(OP_LH, 32'h206, 32'h0, 32'h1234_8001, 1, 1);

        // Misaligned load and store
        ex_aluop = OP_LW; ex_mem_addr = 32'h102; ex_wreg = 1'b1;
        @(negedge clk);
        check_eq("adel", {31'h0, excp_adel}, 32'h1);
        check_eq("adel_req", {31'h0, dbus_req}, 32'h0);
        check_eq("adel_stall", {31'h0, stallreq}, 32'h0);
        check_eq("adel_wreg", {31'h0, mem_wreg}, 32'h0);
        next_cycle();
        ex_aluop = OP_SH; ex_mem_addr = 32'h201;
        @(negedge clk);
        check_eq("ades", {31'h0, excp_ades}, 32'h1);
        check_eq("ades_req", {31'h0, dbus_req}, 32'h0);
        check_eq("ades_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        next_cycle();

        // Non-memory pass-through with a spurious ack
        drive_nop();
        ex_aluop = OP_ADD; ex_wdata = 32'h1357_9BDF; ex_wd = 5'd3; ex_wreg = 1'b1; dbus_ack = 1'b1;
        @(negedge clk);
        check_eq("alu_req", {31'h0, dbus_req}, 32'h0);
        check_eq("alu_wdata", mem_wdata, 32'h1357_9BDF);
        check_eq("alu_wd", {27'h0, mem_wd}, 32'd3);
        check_eq("alu_wreg", {31'h0, mem_wreg}, 32'h1);
        next_cycle();

        // Flush of an aligned load in IDLE
        drive_nop();
        ex_aluop = OP_LW; ex_mem_addr = 32'h400; ex_wd = 5'd4; ex_wreg = 1'b1; flush = 1'b1;
        @(negedge clk);
        check_eq("fl_req", {31'h0, dbus_req}, 32'h0);
        check_eq("fl_nop", {26'h0, mem_wreg, mem_wd}, 32'h0);
        check_eq("fl_wdata", mem_wdata, 32'h0);
        next_cycle();

        // Flush while in WAIT
        drive_nop();
        ex_aluop = OP_LW; ex_mem_addr = 32'h300; ex_wd = 5'd5; ex_wreg = 1'b1;
        @(negedge clk);
        check_eq("fw_stall0", {31'h0, stallreq}, 32'h1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check_eq("fw_req1", {31'h0, dbus_req}, 32'h1);
        check_eq("fw_stall1", {31'h0, stallreq}, 32'h1);
        check_eq("fw_wreg1", {31'h0, mem_wreg}, 32'h0);
        next_cycle();
        drive_nop();
        ex_aluop = OP_ADD; ex_wdata = 32'h1111; ex_wd = 5'd6; ex_wreg = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("dr_state", {30'h0, dbg_state}, {30'h0, ST_DRAIN});
            check_eq("dr_req", {31'h0, dbus_req}, 32'h1);
            check_eq("dr_addr", dbus_addr, 32'h300);
            check_eq("dr_stall", {31'h0, stallreq}, 32'h1);
            check_eq("dr_wreg", {31'h0, mem_wreg}, 32'h0);
            next_cycle();
        end
        dbus_ack = 1'b1; dbus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check_eq("dr_ack_req", {31'h0, dbus_req}, 32'h1);
        check_eq("dr_ack_wreg", {31'h0, mem_wreg}, 32'h0);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        check_eq("dr_exit_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        check_eq("dr_exit_req", {31'h0, dbus_req}, 32'h0);
        check_eq("dr_exit_wdata", mem_wdata, 32'h1111);
        next_cycle();
        run_access(OP_LW, 32'h304, 32'h0, 32'hCAFE_F00D, 0, 0);

        // Reset while WAIT
        ex_aluop = OP_LW; ex_mem_addr = 32'h500; ex_wreg = 1'b1;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mr_req", {31'h0, dbus_req}, 32'h0);
        check_eq("mr_stall", {31'h0, stallreq}, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        check_eq("mr_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        check_eq("mr_req_after", {31'h0, dbus_req}, 32'h0);
        next_cycle();

        // Random aligned accesses
        for (int i = 0; i < 16; i++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = $urandom_range(0, 32'h0fff);
            if (op == OP_LW || op == OP_SW) addr[1:0] = 2'b00;
            else if (op == OP_LH || op == OP_LHU || op == OP_SH) addr[0] = 1'b0;
            run_access(op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
